// File: rtl/alu_seq_pkg.sv
// Shared constants, instruction field positions and FSM state type for the ALU sequencer.
package alu_seq_pkg;

    localparam int unsigned INSTR_W = 11;
    localparam int unsigned OPC_W   = 5;
    localparam int unsigned REG_W   = 2;
    localparam int unsigned RIDX_W  = 2;
    localparam int unsigned NREG    = 4;

    localparam int unsigned OPC_LSB  = 6;
    localparam int unsigned DST_LSB  = 4;
    localparam int unsigned SRCA_LSB = 2;
    localparam int unsigned SRCB_LSB = 0;

    localparam logic [OPC_W-1:0] OP_ALU_MAX = 5'd13;
    localparam logic [OPC_W-1:0] OP_BRS     = 5'd29;
    localparam logic [OPC_W-1:0] OP_LDI     = 5'd30;
    localparam logic [OPC_W-1:0] OP_HALT    = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

endpackage

// File: rtl/alu_seq_regfile.sv
// 4x2-bit register file: two operand read ports, a debug read port, one write port,
// synchronous clear for program restart and async active-low reset.
module alu_seq_regfile
    import alu_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr,
    input  logic              i_we,
    input  logic [RIDX_W-1:0] i_waddr,
    input  logic [REG_W-1:0]  i_wdata,
    input  logic [RIDX_W-1:0] i_raddr_a,
    input  logic [RIDX_W-1:0] i_raddr_b,
    input  logic [RIDX_W-1:0] i_dbg_sel,
    output logic [REG_W-1:0]  o_rdata_a,
    output logic [REG_W-1:0]  o_rdata_b,
    output logic [REG_W-1:0]  o_dbg_data
);

    logic [REG_W-1:0] r_regs [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else if (i_clr) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else if (i_we) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a  = r_regs[i_raddr_a];
    assign o_rdata_b  = r_regs[i_raddr_b];
    assign o_dbg_data = r_regs[i_dbg_sel];

endmodule

// File: rtl/alu_sequencer.sv
// Fetch/decode/execute sequencer driving an external combinational 2-bit ALU.
// Optional BRS (opcode 29) branch instruction enabled by defining ALU_SEQ_BRANCH_EN.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned PC_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               imem_valid,
    output logic [OPC_W-1:0]   alu_opcode,
    output logic [REG_W-1:0]   alu_a,
    output logic [REG_W-1:0]   alu_b,
    input  logic [REG_W-1:0]   alu_res,
    input  logic               alu_status,
    output logic               busy,
    output logic               halted,
    output logic               flag,
    output logic               illegal,
    input  logic [RIDX_W-1:0]  dbg_sel,
    output logic [REG_W-1:0]   dbg_data
);

    state_t              r_state, w_state_nxt;
    logic [PC_W-1:0]     r_pc, w_pc_nxt;
    logic [INSTR_W-1:0]  r_ir;
    logic                r_flag, w_flag_nxt;
    logic                r_illegal, w_illegal_nxt;
    logic                r_imem_req, r_busy, r_halted;
    logic                w_ir_ld, w_clr, w_rf_we;
    logic [REG_W-1:0]    w_rf_wdata;
    logic [OPC_W-1:0]    w_opcode;
    logic [RIDX_W-1:0]   w_dst, w_src_a, w_src_b;

    assign w_opcode = r_ir[OPC_LSB +: OPC_W];
    assign w_dst    = r_ir[DST_LSB +: RIDX_W];
    assign w_src_a  = r_ir[SRCA_LSB +: RIDX_W];
    assign w_src_b  = r_ir[SRCB_LSB +: RIDX_W];

    alu_seq_regfile u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (w_clr),
        .i_we       (w_rf_we),
        .i_waddr    (w_dst),
        .i_wdata    (w_rf_wdata),
        .i_raddr_a  (w_src_a),
        .i_raddr_b  (w_src_b),
        .i_dbg_sel  (dbg_sel),
        .o_rdata_a  (alu_a),
        .o_rdata_b  (alu_b),
        .o_dbg_data (dbg_data)
    );

    // State and architectural registers; status outputs are registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_pc       <= '0;
            r_ir       <= '0;
            r_flag     <= 1'b0;
            r_illegal  <= 1'b0;
            r_imem_req <= 1'b0;
            r_busy     <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_flag     <= w_flag_nxt;
            r_illegal  <= w_illegal_nxt;
            r_imem_req <= (w_state_nxt == ST_FETCH);
            r_busy     <= (w_state_nxt == ST_FETCH) || (w_state_nxt == ST_EXEC);
            r_halted   <= (w_state_nxt == ST_HALT);
            if (w_ir_ld) r_ir <= imem_data;
        end
    end

    // Next-state, PC update and writeback decode
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_flag_nxt    = r_flag;
        w_illegal_nxt = r_illegal;
        w_ir_ld       = 1'b0;
        w_clr         = 1'b0;
        w_rf_we       = 1'b0;
        w_rf_wdata    = alu_res;
        case (r_state)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    w_state_nxt   = ST_FETCH;
                    w_pc_nxt      = '0;
                    w_flag_nxt    = 1'b0;
                    w_illegal_nxt = 1'b0;
                    w_clr         = 1'b1;
                end
            end
            ST_FETCH: begin
                if (imem_valid) begin
                    w_ir_ld     = 1'b1;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_state_nxt = ST_FETCH;
                w_pc_nxt    = r_pc + PC_W'(1);
                if (w_opcode == OP_HALT) begin
                    w_state_nxt = ST_HALT;
                    w_pc_nxt    = r_pc;
                end else if (w_opcode <= OP_ALU_MAX) begin
                    w_rf_we    = 1'b1;
                    w_flag_nxt = alu_status;
                end else if (w_opcode == OP_LDI) begin
                    w_rf_we    = 1'b1;
                    w_rf_wdata = w_src_a;
`ifdef ALU_SEQ_BRANCH_EN
                end else if (w_opcode == OP_BRS) begin
                    if (r_flag) w_pc_nxt = PC_W'(r_ir[5:0]);
`endif
                end else begin
                    w_illegal_nxt = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign imem_req   = r_imem_req;
    assign imem_addr  = r_pc;
    assign alu_opcode = w_opcode;
    assign busy       = r_busy;
    assign halted     = r_halted;
    assign flag       = r_flag;
    assign illegal    = r_illegal;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed scenarios plus random programs
// checked against an instruction-level interpreter model.
module tb_alu_sequencer;

    logic        clk, rst_n, start;
    logic        imem_req, imem_valid;
    logic [3:0]  imem_addr;
    logic [10:0] imem_data;
    logic [4:0]  alu_opcode;
    logic [1:0]  alu_a, alu_b, alu_res;
    logic        alu_status, busy, halted, flag, illegal;
    logic [1:0]  dbg_sel, dbg_data;

    logic        start_w, imem_req_w, imem_valid_w;
    logic [1:0]  imem_addr_w;
    logic [10:0] imem_data_w;
    logic [4:0]  alu_opcode_w;
    logic [1:0]  alu_a_w, alu_b_w, alu_res_w;
    logic        alu_status_w, busy_w, halted_w, flag_w, illegal_w;
    logic [1:0]  dbg_sel_w, dbg_data_w;

    int n_chk = 0;
    int n_err = 0;

    logic [10:0] prog [64];
    int          n_wait;
    int          wcnt;
    int          q_addr[$];

    int m_reg[4];
    bit m_flag, m_ill, m_halt;
    int m_trace[$];
    int m_cycles;

    alu_sequencer #(.PC_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data), .imem_valid(imem_valid),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_res(alu_res), .alu_status(alu_status),
        .busy(busy), .halted(halted), .flag(flag), .illegal(illegal),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    alu_sequencer #(.PC_W(2)) u_dut_w (
        .clk(clk), .rst_n(rst_n), .start(start_w),
        .imem_req(imem_req_w), .imem_addr(imem_addr_w), .imem_data(imem_data_w), .imem_valid(imem_valid_w),
        .alu_opcode(alu_opcode_w), .alu_a(alu_a_w), .alu_b(alu_b_w), .alu_res(alu_res_w), .alu_status(alu_status_w),
        .busy(busy_w), .halted(halted_w), .flag(flag_w), .illegal(illegal_w),
        .dbg_sel(dbg_sel_w), .dbg_data(dbg_data_w)
    );

    // Reference ALU: sum of operands plus low opcode bits, carry-out as status (op 0 = ADD)
    function automatic logic [2:0] alu_f(input logic [4:0] op, input logic [1:0] a, input logic [1:0] b);
        int s;
        s = int'(a) + int'(b) + int'(op[1:0]);
        return 3'(s);
    endfunction

    assign {alu_status, alu_res} = alu_f(alu_opcode, alu_a, alu_b);
    assign alu_res_w    = 2'b00;
    assign alu_status_w = 1'b0;
    // Wrap-test memory: always ready, every word is LDI r[addr], addr^1
    assign imem_valid_w = imem_req_w;
    assign imem_data_w  = {5'd30, imem_addr_w, imem_addr_w ^ 2'b01, 2'b00};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory with n_wait stall cycles before each completion
    always @(negedge clk) begin
        if (imem_req) begin
            if (wcnt >= n_wait) begin
                imem_valid = 1'b1;
                imem_data  = prog[imem_addr];
                q_addr.push_back(int'(imem_addr));
                wcnt = 0;
            end else begin
                imem_valid = 1'b0;
                wcnt++;
            end
        end else begin
            imem_valid = 1'b0;
            wcnt = 0;
        end
    end

    function automatic logic [10:0] mk(input int op, input int dst, input int sa, input int sb);
        return {5'(op), 2'(dst), 2'(sa), 2'(sb)};
    endfunction

    // Instruction-level interpreter of the loaded program
    function automatic void model_run(input int pcw, input int max_instr);
        int pc, nxt, op, dst, sa, sb;
        logic [10:0] w;
        logic [2:0] r;
        pc = 0;
        for (int i = 0; i < 4; i++) m_reg[i] = 0;
        m_flag = 0; m_ill = 0; m_halt = 0; m_cycles = 0;
        m_trace.delete();
        for (int k = 0; k < max_instr; k++) begin
            w   = prog[pc];
            op  = int'(w[10:6]);
            dst = int'(w[5:4]);
            sa  = int'(w[3:2]);
            sb  = int'(w[1:0]);
            m_trace.push_back(pc);
            m_cycles += n_wait + 2;
            nxt = (pc + 1) % (1 << pcw);
            if (op == 31) begin
                m_halt = 1;
                break;
            end else if (op <= 13) begin
                r = alu_f(5'(op), 2'(m_reg[sa]), 2'(m_reg[sb]));
                m_reg[dst] = int'(r[1:0]);
                m_flag = r[2];
            end else if (op == 30) begin
                m_reg[dst] = sa;
`ifdef ALU_SEQ_BRANCH_EN
            end else if (op == 29) begin
                if (m_flag) nxt = int'(w[5:0]) % (1 << pcw);
`endif
            end else begin
                m_ill = 1;
            end
            pc = nxt;
        end
    endfunction

    task automatic run_prog(input int wait_cyc, input int limit, output int cyc, output int req_cnt);
        n_wait = wait_cyc;
        q_addr.delete();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc = 0;
        req_cnt = int'(imem_req);
        while (!halted && cyc < limit) begin
            @(negedge clk);
            cyc++;
            req_cnt += int'(imem_req);
        end
    endtask

    task automatic test_reset();
        #2;
        n_chk++;
        if ({imem_req, busy, halted, flag, illegal} !== 5'b0) begin
            n_err++; $display("FAIL reset_ctrl: got %b want 00000", {imem_req, busy, halted, flag, illegal});
        end
        n_chk++;
        if ({imem_addr, alu_opcode, alu_a, alu_b} !== 13'd0) begin
            n_err++; $display("FAIL reset_data: addr=%0d op=%0d a=%0d b=%0d want all 0", imem_addr, alu_opcode, alu_a, alu_b);
        end
        n_chk++;
        if (imem_req_w !== 1'b0) begin
            n_err++; $display("FAIL reset_req_w: got %b want 0", imem_req_w);
        end
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i); #1;
            n_chk++;
            if (dbg_data !== 2'd0) begin
                n_err++; $display("FAIL reset_reg%0d: got %0d want 0", i, dbg_data);
            end
        end
    endtask

    task automatic test_ldi_add(input int w);
        int cyc, rc;
        int exp_reg[4];
        exp_reg = '{0, 3, 1, 0};
        prog[0] = mk(30, 1, 3, 0);
        prog[1] = mk(30, 2, 1, 0);
        prog[2] = mk(0, 0, 1, 2);
        prog[3] = mk(31, 0, 0, 0);
        run_prog(w, 200, cyc, rc);
        n_chk++;
        if (cyc !== 8 + 4 * w) begin
            n_err++; $display("FAIL ldi_add_latency(w=%0d): got %0d want %0d", w, cyc, 8 + 4 * w);
        end
        n_chk++;
        if (rc !== 4 * (1 + w)) begin
            n_err++; $display("FAIL ldi_add_req_cycles(w=%0d): got %0d want %0d", w, rc, 4 * (1 + w));
        end
        n_chk++;
        if ({halted, flag, illegal, busy} !== 4'b1100) begin
            n_err++; $display("FAIL ldi_add_status(w=%0d): halted/flag/illegal/busy=%b want 1100", w, {halted, flag, illegal, busy});
        end
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i); #1;
            n_chk++;
            if (dbg_data !== 2'(exp_reg[i])) begin
                n_err++; $display("FAIL ldi_add_reg%0d(w=%0d): got %0d want %0d", i, w, dbg_data, exp_reg[i]);
            end
        end
        n_chk++;
        if (q_addr.size() !== 4 || q_addr[3] !== 3) begin
            n_err++; $display("FAIL ldi_add_fetches(w=%0d): got %0d fetches want 4", w, q_addr.size());
        end
    endtask

    task automatic test_pc_wrap();
        int seq[$];
        int cyc;
        @(negedge clk) start_w = 1'b1;
        @(negedge clk) start_w = 1'b0;
        cyc = 0;
        while (seq.size() < 5 && cyc < 40) begin
            if (imem_req_w) seq.push_back(int'(imem_addr_w));
            @(negedge clk);
            cyc++;
        end
        n_chk++;
        if (seq.size() !== 5) begin
            n_err++; $display("FAIL wrap_count: got %0d fetches want 5", seq.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_chk++;
                if (seq[i] !== i % 4) begin
                    n_err++; $display("FAIL wrap_addr[%0d]: got %0d want %0d", i, seq[i], i % 4);
                end
            end
        end
        n_chk++;
        if (halted_w !== 1'b0 || illegal_w !== 1'b0) begin
            n_err++; $display("FAIL wrap_halted: halted=%b illegal=%b want 0 0", halted_w, illegal_w);
        end
        for (int i = 0; i < 4; i++) begin
            dbg_sel_w = 2'(i); #1;
            n_chk++;
            if (dbg_data_w !== 2'(i ^ 1)) begin
                n_err++; $display("FAIL wrap_reg%0d: got %0d want %0d", i, dbg_data_w, i ^ 1);
            end
        end
    endtask

    task automatic test_illegal();
        int cyc, rc;
        prog[0] = mk(30, 1, 2, 0);
        prog[1] = mk(20, 1, 3, 3);
        prog[2] = mk(31, 0, 0, 0);
        run_prog(0, 100, cyc, rc);
        dbg_sel = 2'd1; #1;
        n_chk++;
        if (dbg_data !== 2'd2) begin
            n_err++; $display("FAIL illegal_r1: got %0d want 2", dbg_data);
        end
        repeat (4) @(negedge clk);
        n_chk++;
        if (illegal !== 1'b1 || flag !== 1'b0 || halted !== 1'b1) begin
            n_err++; $display("FAIL illegal_sticky: illegal=%b flag=%b halted=%b want 1 0 1", illegal, flag, halted);
        end
        prog[0] = mk(31, 0, 0, 0);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n_chk++;
        if (illegal !== 1'b0 || halted !== 1'b0 || imem_req !== 1'b1) begin
            n_err++; $display("FAIL illegal_clear: illegal=%b halted=%b req=%b want 0 0 1", illegal, halted, imem_req);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_branch(input int imm1);
        int cyc, rc, exp_next, exp_ill;
        prog[0] = mk(30, 1, imm1, 0);
        prog[1] = mk(30, 2, 1, 0);
        prog[2] = mk(0, 0, 1, 2);
        prog[3] = {5'd29, 6'd5};
        prog[4] = mk(31, 0, 0, 0);
        prog[5] = mk(31, 0, 0, 0);
`ifdef ALU_SEQ_BRANCH_EN
        exp_next = (imm1 + 1 >= 4) ? 5 : 4;
        exp_ill  = 0;
`else
        exp_next = 4;
        exp_ill  = 1;
`endif
        run_prog(0, 100, cyc, rc);
        n_chk++;
        if (q_addr.size() !== 5 || q_addr[4] !== exp_next) begin
            n_err++; $display("FAIL branch_next(imm=%0d): fetches=%0d last=%0d want 5 fetches last=%0d",
                              imm1, q_addr.size(), (q_addr.size() > 0) ? q_addr[q_addr.size()-1] : -1, exp_next);
        end
        n_chk++;
        if (int'(illegal) !== exp_ill) begin
            n_err++; $display("FAIL branch_illegal(imm=%0d): got %b want %0d", imm1, illegal, exp_ill);
        end
    endtask

    task automatic test_random(input int iters);
        int cyc, rc, kind, w;
        for (int it = 0; it < iters; it++) begin
            for (int i = 0; i < 7; i++) begin
                kind = int'($urandom_range(0, 9));
                if (kind <= 4)      prog[i] = mk(int'($urandom_range(0, 13)), int'($urandom_range(0, 3)),
                                                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
                else if (kind <= 6) prog[i] = mk(30, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0);
                else if (kind == 7) prog[i] = mk(int'($urandom_range(14, 28)), int'($urandom_range(0, 3)), 1, 2);
                else if (kind == 8) prog[i] = mk(31, 0, 0, 0);
                else                prog[i] = mk(0, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 3);
            end
            prog[7] = mk(31, 0, 0, 0);
            w = int'($urandom_range(0, 3));
            n_wait = w;
            model_run(4, 64);
            run_prog(w, m_cycles + 10, cyc, rc);
            n_chk++;
            if (cyc !== m_cycles) begin
                n_err++; $display("FAIL rand%0d_cycles: got %0d want %0d", it, cyc, m_cycles);
            end
            n_chk++;
            if ({halted, flag, illegal} !== {m_halt, m_flag, m_ill}) begin
                n_err++; $display("FAIL rand%0d_status: halted/flag/illegal=%b want %b", it,
                                  {halted, flag, illegal}, {m_halt, m_flag, m_ill});
            end
            for (int i = 0; i < 4; i++) begin
                dbg_sel = 2'(i); #1;
                n_chk++;
                if (dbg_data !== 2'(m_reg[i])) begin
                    n_err++; $display("FAIL rand%0d_reg%0d: got %0d want %0d", it, i, dbg_data, m_reg[i]);
                end
            end
            n_chk++;
            if (q_addr != m_trace) begin
                n_err++; $display("FAIL rand%0d_trace: got %0d fetches want %0d", it, q_addr.size(), m_trace.size());
            end
        end
    endtask

    task automatic test_reset_mid_fetch();
        prog[0] = mk(31, 0, 0, 0);
        n_wait = 100;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if (imem_req !== 1'b1) begin
            n_err++; $display("FAIL midfetch_pre: req=%b want 1", imem_req);
        end
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (imem_req !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL midfetch_async: req=%b busy=%b want 0 0", imem_req, busy);
        end
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({imem_req, busy, halted, imem_addr} !== 7'd0) begin
            n_err++; $display("FAIL midfetch_idle: req=%b busy=%b halted=%b addr=%0d want 0 0 0 0",
                              imem_req, busy, halted, imem_addr);
        end
        n_wait = 0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; start_w = 1'b0;
        dbg_sel = 2'd0; dbg_sel_w = 2'd0;
        imem_valid = 1'b0; imem_data = '0;
        n_wait = 0; wcnt = 0;
        for (int i = 0; i < 64; i++) prog[i] = 11'h7C0;
        test_reset();
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        test_ldi_add(0);
        test_ldi_add(3);
        test_pc_wrap();
        test_illegal();
        test_branch(3);
        test_branch(1);
        test_random(20);
        test_reset_mid_fetch();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
